// File: rtl/ghr_pkg.sv
// ============================================================================
// Module      : ghr_pkg
// Description : Shared GHR constants, entry geometry and controller state enum.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ghr_pkg;

  localparam int ENTRY_W   = 9;
  localparam int MAX_GROUP = 4;
  localparam int GROUP_W   = ENTRY_W * MAX_GROUP;

  localparam logic [2:0] RECOVER_CODE = 3'b111;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } ghr_state_e;

endpackage

`default_nettype wire

// File: rtl/ghr_stat_cnt.sv
// ============================================================================
// Module      : ghr_stat_cnt
// Description : Saturating event counter; adds a small increment each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ghr_stat_cnt #(
  parameter int W     = 16,
  parameter int INC_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [INC_W-1:0] inc,
  output logic [W-1:0]     cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic [W:0]   w_sum;

  // The carry out of the widened sum is the saturation condition
  assign w_sum = {1'b0, cnt_q} + (W+1)'(inc);

  always_comb begin
    cnt_d = w_sum[W] ? {W{1'b1}} : w_sum[W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

`default_nettype wire

// File: rtl/ghr_update_ctrl.sv
// ============================================================================
// Module      : ghr_update_ctrl
// Description : Tracks in-flight branches and issues registered GHR update
//               strobes for pushes, resolves and mispredict recovery.
//               Define GHR_CTRL_STATS_EN to add push/mispredict counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ghr_update_ctrl
  import ghr_pkg::*;
#(
  parameter int MAX_PENDING = 20,
  parameter int FLUSH_CYC   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fe_valid,
  input  logic [2:0]         fe_bnum,
  input  logic [GROUP_W-1:0] fe_entries,
  output logic               fe_ready,
  input  logic               ex_valid,
  input  logic               ex_mispredict,
  output logic               upd_fire,
  output logic [2:0]         upd_pass_num,
  output logic [7:0]         upd_new_pending,
  output logic [GROUP_W-1:0] upd_entries,
  output logic [7:0]         pending_cnt,
  output logic               err
`ifdef GHR_CTRL_STATS_EN
  ,
  output logic [15:0]        stat_push,
  output logic [15:0]        stat_mispred
`endif
);

  localparam int               FCNT_W     = (FLUSH_CYC < 1) ? 1 : $clog2(FLUSH_CYC + 1);
  localparam logic [FCNT_W-1:0] FLUSH_LOAD = FCNT_W'(FLUSH_CYC);
  localparam logic [9:0]       MAX_PEND_W = 10'(MAX_PENDING);

  ghr_state_e          state_q, state_d;
  logic [FCNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic [7:0]          pending_q, pending_d;
  logic                fire_q, fire_d;
  logic [2:0]          pass_q, pass_d;
  logic [7:0]          newp_q, newp_d;
  logic [GROUP_W-1:0]  ent_q, ent_d;
  logic                err_q, err_d;

  logic                w_has_pend;
  logic                w_correct;
  logic                w_recover;
  logic                w_bnum_ok;
  logic [9:0]          w_proj;
  logic                w_push;
  logic [2:0]          w_push_n;

  assign w_has_pend = (pending_q != 8'd0);
  assign w_correct  = ex_valid & ~ex_mispredict & w_has_pend;
  assign w_recover  = (state_q == RUN) & ex_valid & ex_mispredict & w_has_pend;
  assign w_bnum_ok  = (fe_bnum <= 3'(MAX_GROUP));
  assign w_proj     = {2'b00, pending_q} + {7'd0, fe_bnum} - {9'd0, w_correct};

  // Any mispredict blocks the push, even one that is ignored because P=0
  assign fe_ready = rst & (state_q == RUN) & ~(ex_valid & ex_mispredict) &
                    w_bnum_ok & (w_proj <= MAX_PEND_W);

  assign w_push   = fe_valid & fe_ready;
  assign w_push_n = w_push ? fe_bnum : 3'd0;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      RUN: begin
        if (w_recover) begin
          state_d     = FLUSH;
          flush_cnt_d = FLUSH_LOAD;
        end
      end
      FLUSH: begin
        if (flush_cnt_q <= FCNT_W'(1)) begin
          state_d     = RUN;
          flush_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q - FCNT_W'(1);
        end
      end
      default: begin
        state_d     = RUN;
        flush_cnt_d = '0;
      end
    endcase
  end

  // Output / datapath logic; payload fields hold their value between strobes
  always_comb begin
    fire_d    = 1'b0;
    pass_d    = pass_q;
    newp_d    = newp_q;
    ent_d     = ent_q;
    pending_d = pending_q;
    err_d     = err_q | (ex_valid & ~w_has_pend) | (fe_valid & ~w_bnum_ok);

    if (w_recover) begin
      fire_d    = 1'b1;
      pass_d    = RECOVER_CODE;
      newp_d    = pending_q;
      ent_d     = '0;
      pending_d = 8'd0;
    end else if ((w_push_n != 3'd0) || w_correct) begin
      fire_d    = 1'b1;
      pass_d    = w_push_n;
      pending_d = pending_q + {5'd0, w_push_n} - {7'd0, w_correct};
      newp_d    = pending_d;
      ent_d     = (w_push_n != 3'd0) ? fe_entries : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fire_q    <= 1'b0;
      pass_q    <= 3'd0;
      newp_q    <= 8'd0;
      ent_q     <= '0;
      pending_q <= 8'd0;
      err_q     <= 1'b0;
    end else begin
      fire_q    <= fire_d;
      pass_q    <= pass_d;
      newp_q    <= newp_d;
      ent_q     <= ent_d;
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  assign upd_fire        = fire_q;
  assign upd_pass_num    = pass_q;
  assign upd_new_pending = newp_q;
  assign upd_entries     = ent_q;
  assign pending_cnt     = pending_q;
  assign err             = err_q;

`ifdef GHR_CTRL_STATS_EN
  ghr_stat_cnt #(
    .W     (16),
    .INC_W (3)
  ) u_stat_push (
    .clk (clk),
    .rst (rst),
    .inc (w_push_n),
    .cnt (stat_push)
  );

  ghr_stat_cnt #(
    .W     (16),
    .INC_W (1)
  ) u_stat_mispred (
    .clk (clk),
    .rst (rst),
    .inc (w_recover),
    .cnt (stat_mispred)
  );
`endif

endmodule

`default_nettype wire

// File: tb/tb_ghr_update_ctrl.sv
// ============================================================================
// Module      : tb_ghr_update_ctrl
// Description : Directed self-checking bench for ghr_update_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ghr_update_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        fe_valid;
  logic [2:0]  fe_bnum;
  logic [35:0] fe_entries;
  logic        fe_ready;
  logic        ex_valid;
  logic        ex_mispredict;
  logic        upd_fire;
  logic [2:0]  upd_pass_num;
  logic [7:0]  upd_new_pending;
  logic [35:0] upd_entries;
  logic [7:0]  pending_cnt;
  logic        err;
`ifdef GHR_CTRL_STATS_EN
  logic [15:0] stat_push;
  logic [15:0] stat_mispred;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [35:0] ENT_A = 36'h9_8765_4321;
  localparam logic [35:0] ENT_B = 36'h1_2345_6789;

  ghr_update_ctrl #(
    .MAX_PENDING (20),
    .FLUSH_CYC   (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .fe_valid        (fe_valid),
    .fe_bnum         (fe_bnum),
    .fe_entries      (fe_entries),
    .fe_ready        (fe_ready),
    .ex_valid        (ex_valid),
    .ex_mispredict   (ex_mispredict),
    .upd_fire        (upd_fire),
    .upd_pass_num    (upd_pass_num),
    .upd_new_pending (upd_new_pending),
    .upd_entries     (upd_entries),
    .pending_cnt     (pending_cnt),
    .err             (err)
`ifdef GHR_CTRL_STATS_EN
    ,
    .stat_push       (stat_push),
    .stat_mispred    (stat_mispred)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic apply(input logic v, input logic [2:0] n, input logic [35:0] e,
                       input logic xv, input logic xm);
    fe_valid = v; fe_bnum = n; fe_entries = e; ex_valid = xv; ex_mispredict = xm;
    #1;
  endtask

  // Advance one edge, sample at posedge+1, then return inputs to idle
  task automatic step;
    @(posedge clk); #1;
    fe_valid = 1'b0; fe_bnum = 3'd0; fe_entries = '0; ex_valid = 1'b0; ex_mispredict = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; fe_valid = 1'b0; fe_bnum = 3'd0; fe_entries = '0;
    ex_valid = 1'b0; ex_mispredict = 1'b0;
    #1;
    chk("rst_ready", fe_ready, 0);
    chk("rst_fire", upd_fire, 0);
    chk("rst_pend", pending_cnt, 0);
    chk("rst_err", err, 0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Push 3 from empty
    apply(1, 3'd3, ENT_A, 0, 0);
    chk("push3_ready", fe_ready, 1);
    step;
    chk("push3_fire", upd_fire, 1);
    chk("push3_pass", upd_pass_num, 3);
    chk("push3_newp", upd_new_pending, 3);
    chk("push3_pend", pending_cnt, 3);
    chk("push3_ent", upd_entries, ENT_A);
    step;
    chk("idle_fire", upd_fire, 0);

    // Correct resolve alone
    apply(0, 3'd0, '0, 1, 0);
    step;
    chk("res_fire", upd_fire, 1);
    chk("res_pass", upd_pass_num, 0);
    chk("res_newp", upd_new_pending, 2);
    chk("res_ent", upd_entries, 0);
    chk("res_pend", pending_cnt, 2);

    // Zero-branch push is a no-op
    apply(1, 3'd0, ENT_B, 0, 0);
    chk("push0_ready", fe_ready, 1);
    step;
    chk("push0_fire", upd_fire, 0);
    chk("push0_pend", pending_cnt, 2);

    // Fill to 18
    for (int i = 0; i < 4; i++) begin
      apply(1, 3'd4, ENT_B, 0, 0);
      step;
    end
    chk("fill_pend", pending_cnt, 18);
    chk("fill_ent", upd_entries, ENT_B);

    // 18+3 overflows; with a correct resolve it fits exactly
    apply(1, 3'd3, ENT_A, 0, 0);
    chk("full_ready", fe_ready, 0);
    step;
    chk("full_fire", upd_fire, 0);
    chk("full_pend", pending_cnt, 18);
    apply(1, 3'd3, ENT_A, 1, 0);
    chk("pr_ready", fe_ready, 1);
    step;
    chk("pr_fire", upd_fire, 1);
    chk("pr_pass", upd_pass_num, 3);
    chk("pr_newp", upd_new_pending, 20);
    chk("pr_pend", pending_cnt, 20);

    for (int i = 0; i < 15; i++) begin
      apply(0, 3'd0, '0, 1, 0);
      step;
    end
    chk("drain_pend", pending_cnt, 5);

    // Mispredict beats a simultaneous push
    apply(1, 3'd2, ENT_A, 1, 1);
    chk("mp_ready", fe_ready, 0);
    step;
    chk("mp_fire", upd_fire, 1);
    chk("mp_pass", upd_pass_num, 7);
    chk("mp_newp", upd_new_pending, 5);
    chk("mp_ent", upd_entries, 0);
    chk("mp_pend", pending_cnt, 0);
    chk("fl1_ready", fe_ready, 0);
    step;
    chk("fl2_ready", fe_ready, 0);
    chk("fl2_fire", upd_fire, 0);
    step;
    chk("fl_done_ready", fe_ready, 1);
    chk("fl_err", err, 0);

    // Resolve with nothing pending
    apply(0, 3'd0, '0, 1, 0);
    step;
    chk("p0res_fire", upd_fire, 0);
    chk("p0res_err", err, 1);
    step; step; step;
    chk("err_sticky", err, 1);

    // Reset during the first FLUSH cycle
    apply(1, 3'd2, ENT_A, 0, 0);
    step;
    apply(0, 3'd0, '0, 1, 1);
    step;
    chk("pre_rst_pass", upd_pass_num, 7);
    rst = 1'b0;
    #1;
    chk("mr_fire", upd_fire, 0);
    chk("mr_pass", upd_pass_num, 0);
    chk("mr_newp", upd_new_pending, 0);
    chk("mr_ent", upd_entries, 0);
    chk("mr_pend", pending_cnt, 0);
    chk("mr_err", err, 0);
    chk("mr_ready", fe_ready, 0);
    @(posedge clk);
    @(negedge clk); rst = 1'b1;
    #1;
    chk("rel_ready", fe_ready, 1);
    @(posedge clk); #1;
    chk("rel_fire", upd_fire, 0);

    // Statistics scenario: 3 pushes of 4, then a mispredict
    do_reset;
    for (int i = 0; i < 3; i++) begin
      apply(1, 3'd4, ENT_B, 0, 0);
      step;
    end
    chk("st_pend", pending_cnt, 12);
    apply(0, 3'd0, '0, 1, 1);
    step;
    chk("st_newp", upd_new_pending, 12);
`ifdef GHR_CTRL_STATS_EN
    chk("st_push", stat_push, 12);
    chk("st_mispred", stat_mispred, 1);
`endif
    step; step;

    // Illegal group size
    apply(1, 3'd5, ENT_A, 0, 0);
    chk("bn5_ready", fe_ready, 0);
    step;
    chk("bn5_err", err, 1);
    chk("bn5_fire", upd_fire, 0);
    chk("bn5_pend", pending_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
